// File: rtl/dcm_lock_sequencer_pkg.sv
// dcm_lock_sequencer_pkg: sequencer state encoding and default parameter values.
package dcm_seq_pkg;
    typedef enum logic [2:0] {RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_e;
    localparam int DEF_RST_CYCLES    = 3;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int DEF_CNT_W         = 16;
endpackage

// File: rtl/dcm_lock_sequencer_if.sv
// dcm_lock_sequencer_if: restart/lock inputs and reset/status outputs of the sequencer.
// DCM_STATUS_MON_EN adds the dcm_clkin_stopped status input.
interface dcm_lock_sequencer_if;
    logic       config_rst;
    logic       dcm_locked;
    logic       dcm_rst;
    logic       sys_rst;
    logic       lock_fail;
    logic [2:0] retry_cnt;
`ifdef DCM_STATUS_MON_EN
    logic       dcm_clkin_stopped;
    modport master (output config_rst, dcm_locked, dcm_clkin_stopped, input dcm_rst, sys_rst, lock_fail, retry_cnt);
    modport slave (input config_rst, dcm_locked, dcm_clkin_stopped, output dcm_rst, sys_rst, lock_fail, retry_cnt);
`else
    modport master (output config_rst, dcm_locked, input dcm_rst, sys_rst, lock_fail, retry_cnt);
    modport slave (input config_rst, dcm_locked, output dcm_rst, sys_rst, lock_fail, retry_cnt);
`endif
endinterface

// File: rtl/dcm_lock_sequencer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) sync_q <= '0;
        else sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer: DCM reset pulse, lock wait with timeout/retries, stable-lock sys_rst release.
// DCM_STATUS_MON_EN adds clkin-stopped monitoring (lock loss / immediate retry).
module dcm_lock_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input logic clkin,
    input logic rst_n,
    dcm_lock_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       MAX_R     = 3'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic             dcm_rst_q, sys_rst_q, lock_fail_q;
    logic             lock_s, stop_s, lost;

    sync_2ff u_lock_sync (.clk_i(clkin), .rst_ni(rst_n), .d_i(bus.dcm_locked), .q_o(lock_s));
`ifdef DCM_STATUS_MON_EN
    sync_2ff u_stop_sync (.clk_i(clkin), .rst_ni(rst_n), .d_i(bus.dcm_clkin_stopped), .q_o(stop_s));
`else
    assign stop_s = 1'b0;
`endif
    assign lost = !lock_s || stop_s;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (bus.config_rst) begin
            state_d = RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET:     if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: if (stop_s || (!lock_s && cnt_q == TO_LAST)) begin
                               retry_d = retry_q + 3'd1;
                               state_d = (retry_d == MAX_R) ? FAIL : RESET;
                           end else if (lock_s) state_d = STABLE;
                STABLE:    if (lost) state_d = RESET;
                           else if (cnt_q == STAB_LAST) state_d = RUN;
                RUN:       if (lost) begin
                               state_d = RESET;
                               retry_d = '0;
                           end
                default:   state_d = state_q;
            endcase
        end
        // Counter restarts on every state change and saturates rather than wrapping.
        cnt_d = (bus.config_rst || state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
    end

    always_ff @(posedge clkin or negedge rst_n)
        if (!rst_n) begin
            state_q     <= RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            dcm_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            dcm_rst_q   <= state_d == RESET || state_d == FAIL;
            sys_rst_q   <= state_d != RUN;
            lock_fail_q <= state_d == FAIL;
        end

    assign bus.dcm_rst   = dcm_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.lock_fail = lock_fail_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer: directed scoreboard bench for the DCM lock sequencer.
module tb_dcm_lock_sequencer;
    logic clkin = 1'b0;
    logic rst_n;
    always #5 clkin = ~clkin;

    dcm_lock_sequencer_if bus ();
    dcm_lock_sequencer #(
        .RST_CYCLES(3), .LOCK_TIMEOUT(100), .STABLE_CYCLES(1024), .MAX_RETRIES(2), .CNT_W(16)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {string tag; logic [31:0] want;} exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] st(logic d, logic s, logic f, logic [2:0] r);
        return {26'b0, d, s, f, r};
    endfunction

    function automatic logic [31:0] snap();
        return st(bus.dcm_rst, bus.sys_rst, bus.lock_fail, bus.retry_cnt);
    endfunction

    function automatic logic sig(int sel);
        return sel == 0 ? bus.dcm_rst : sel == 1 ? bus.sys_rst : bus.lock_fail;
    endfunction

    task automatic push(input string tag, input logic [31:0] want);
        exp_t e;
        e.tag = tag;
        e.want = want;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %0h want nothing", got);
        end else begin
            e = sb.pop_front();
            assert (got === e.want) else begin
                errors++;
                $error("FAIL %s: got %0h want %0h", e.tag, got, e.want);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Counts rising edges until the selected output equals val; an expired bound returns the bound.
    task automatic edges_until(input int sel, input logic val, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clkin);
            #1;
            n++;
        end while (sig(sel) !== val && n < bound);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int falls;
        logic prev;
        rst_n = 1'b0;
        bus.config_rst = 1'b0;
        bus.dcm_locked = 1'b0;
`ifdef DCM_STATUS_MON_EN
        bus.dcm_clkin_stopped = 1'b0;
`endif
        cycles(3);
        push("reset_state", st(1, 1, 0, 0)); pop_check(snap());

        push("rst_width", 3);
        rst_n = 1'b1;
        edges_until(0, 1'b0, 20, n); pop_check(n);
        push("wait_lock_state", st(0, 1, 0, 0)); pop_check(snap());
        cycles(7);
        bus.dcm_locked = 1'b1;
        push("lock_to_run", 1027);
        edges_until(1, 1'b0, 2000, n); pop_check(n);
        push("run_state", st(0, 0, 0, 0)); pop_check(snap());

        bus.dcm_locked = 1'b0;
        cycles(1);
        bus.dcm_locked = 1'b1;
        push("loss_latency", 3);
        edges_until(1, 1'b1, 20, n); pop_check(n + 1);
        push("loss_state", st(1, 1, 0, 0)); pop_check(snap());
        push("loss_rst_width", 3);
        edges_until(0, 1'b0, 20, n); pop_check(n);
        push("restable_wait", 1025);
        edges_until(1, 1'b0, 2000, n); pop_check(n);

        bus.dcm_locked = 1'b0;
        push("loss_latency2", 3);
        edges_until(1, 1'b1, 20, n); pop_check(n);
        push("retry_rst_width", 3);
        edges_until(0, 1'b0, 20, n); pop_check(n);
        push("timeout_latency", 100);
        edges_until(0, 1'b1, 300, n); pop_check(n);
        push("retry1_state", st(1, 1, 0, 1)); pop_check(snap());
        bus.dcm_locked = 1'b1;
        push("retry_rst_width2", 3);
        edges_until(0, 1'b0, 20, n); pop_check(n);
        cycles(501);
        push("stable_midway", st(0, 1, 0, 1)); pop_check(snap());
        bus.dcm_locked = 1'b0;
        cycles(1);
        bus.dcm_locked = 1'b1;
        push("glitch_latency", 3);
        edges_until(0, 1'b1, 20, n); pop_check(n + 1);
        push("glitch_state", st(1, 1, 0, 1)); pop_check(snap());

        bus.dcm_locked = 1'b0;
        bus.config_rst = 1'b1;
        cycles(1);
        bus.config_rst = 1'b0;
        push("cfg_clear", st(1, 1, 0, 0)); pop_check(snap());
        falls = 0;
        n = 1;
        while (!bus.lock_fail && n < 1000) begin
            prev = bus.dcm_rst;
            cycles(1);
            n++;
            if (prev && !bus.dcm_rst) falls++;
        end
        push("fail_latency", 207); pop_check(n);
        push("fail_falls", 2); pop_check(falls);
        push("fail_state", st(1, 1, 1, 2)); pop_check(snap());
        cycles(20);
        push("fail_hold", st(1, 1, 1, 2)); pop_check(snap());
        bus.config_rst = 1'b1;
        cycles(1);
        bus.config_rst = 1'b0;
        push("fail_exit", st(1, 1, 0, 0)); pop_check(snap());

        bus.dcm_locked = 1'b1;
        edges_until(1, 1'b0, 2000, n);
        push("recover_run", st(0, 0, 0, 0)); pop_check(snap());
`ifdef DCM_STATUS_MON_EN
        bus.dcm_clkin_stopped = 1'b1;
        push("stop_latency", 3);
        edges_until(1, 1'b1, 20, n); pop_check(n);
        push("stop_state", st(1, 1, 0, 0)); pop_check(snap());
        bus.dcm_clkin_stopped = 1'b0;
        push("stop_rst_width", 3);
        edges_until(0, 1'b0, 20, n); pop_check(n);
        push("stop_restable", 1025);
        edges_until(1, 1'b0, 2000, n); pop_check(n);
`endif

        #3;
        rst_n = 1'b0;
        #1;
        push("async_reset", st(1, 1, 0, 0)); pop_check(snap());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcm_lock_sequencer.md
# dcm_lock_sequencer

Sequences DCM reset and lock acquisition directly downstream of the configuration-reset pulse generator. Consumes its `config_rst` pulse and drives the DCM `RST` pin for a guaranteed minimum width. Waits for `LOCKED` with a timeout and bounded retries, then releases a system reset only after lock has been continuously stable. Any lock loss re-arms the whole sequence and re-asserts the system reset.

## Interface
- `RST_CYCLES`, default 3: `dcm_rst` high width in `clkin` cycles. Must be ≥3, the DCM minimum.
- `LOCK_TIMEOUT`, default 65535: cycles to wait for synchronized lock before a retry.
- `STABLE_CYCLES`, default 1024: continuous synchronized-lock cycles required before `sys_rst` release.
- `MAX_RETRIES`, default 7: failed lock attempts allowed before entering FAIL. Must be ≥1.
- `CNT_W`, default 16: width of the shared cycle counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- `clkin`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `config_rst`  in  1  restart request from the configuration-reset generator; level, active high.
- `dcm_locked`  in  1  DCM LOCKED; asynchronous to `clkin`, synchronized internally.
- `dcm_rst`  out  1  DCM RST drive; active high.
- `sys_rst`  out  1  downstream system reset; active high.
- `lock_fail`  out  1  high while in FAIL.
- `retry_cnt`  out  3  failed attempts since the last restart; saturates at MAX_RETRIES.

## Operation
- `dcm_locked` passes through a 2-flop synchronizer to give `lock_s`.
- States and transitions:
  - RESET: `dcm_rst`=1; counts RST_CYCLES, then goes to WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: `lock_s`=1 → STABLE.
    - Counter reaches LOCK_TIMEOUT−1 → `retry_cnt`+1; then FAIL if the new value equals MAX_RETRIES, else RESET.
  - STABLE: `lock_s`=0 → RESET, no retry increment. STABLE_CYCLES consecutive high cycles → RUN.
  - RUN: `lock_s`=0 → RESET, and `retry_cnt` is cleared.
  - FAIL: `dcm_rst`=1 and `sys_rst`=1 held; exits only on `config_rst` or `rst_n`.
- `config_rst`=1 in any state forces RESET next cycle, clears the counter and `retry_cnt`, and wins over every other transition. While it stays high, the FSM stays in RESET with the counter held at 0.
- `sys_rst`=0 only in RUN; `dcm_rst`=1 only in RESET and FAIL. Both outputs are registered, decoded from the next state.
- The counter is unsigned, clears on every state change, and never wraps within a state.

## Timing
- Reset values: state=RESET, `dcm_rst`=1, `sys_rst`=1, `lock_fail`=0, `retry_cnt`=0, synchronizer=0.
- After `rst_n` deasserts, `dcm_rst` stays high for exactly RST_CYCLES cycles.
- `dcm_locked` rise → STABLE entry: 3 cycles (2 synchronizer + 1 FSM).
- STABLE entry → `sys_rst` falling: STABLE_CYCLES cycles.
- `dcm_locked` fall in RUN → `sys_rst` high: ≤3 cycles. `dcm_rst` rises in the same cycle.
- `config_rst` sampled high at edge N → `dcm_rst`=1 and `sys_rst`=1 at edge N+1.
- Timeout fires in the cycle after the counter holds LOCK_TIMEOUT−1.
- `rst_n` asserted mid-sequence → all outputs go to their reset values immediately, asynchronously.

## Configuration
- `DCM_STATUS_MON_EN` defined: adds input port `dcm_clkin_stopped` (1 bit, DCM STATUS[1]).
  - The port is synchronized like `dcm_locked`.
  - Synchronized high in STABLE or RUN is treated exactly as lock loss.
  - Synchronized high in WAIT_LOCK forces an immediate retry, counted as a timeout.
- `DCM_STATUS_MON_EN` undefined: the port does not exist and behaviour is as above.

## Structure
- Package `dcm_seq_pkg`: state enum (RESET, WAIT_LOCK, STABLE, RUN, FAIL) and default parameter constants.
- One sub-module `sync_2ff`: a 1-bit two-flop synchronizer with async active-low reset. It is instanced for `lock_s`, and for the clock-stopped status when the macro is enabled.

## Test plan
- Release `rst_n`, assert `dcm_locked` 10 cycles later → `dcm_rst` high for exactly 3 cycles; `sys_rst` falls 3+1024 cycles after the `dcm_locked` rise.
- `dcm_locked` stuck low, LOCK_TIMEOUT=100, MAX_RETRIES=2 → two RESET pulses, then `lock_fail`=1, `retry_cnt`=2, `sys_rst` held 1.
- In RUN, drop `dcm_locked` for 1 cycle → `sys_rst` high within 3 cycles, a new 3-cycle `dcm_rst` pulse, and a full STABLE wait again.
- In STABLE, glitch `dcm_locked` low at count 500 → return to RESET with `retry_cnt` unchanged.
- In FAIL, pulse `config_rst` for 1 cycle → next cycle `dcm_rst`=1, `retry_cnt`=0, `lock_fail`=0.
- With `DCM_STATUS_MON_EN`, assert `dcm_clkin_stopped` in RUN → same response as lock loss.
